fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined RV32I core; successor to the combinational forwarding selector.
- Keeps an internal shadow pipeline of in-flight destination registers (EX and every forwardable stage behind it).
- Decodes RV32I opcode classes itself and generates EX-stage operand forwarding selects plus the load-use stall/bubble for the decode stage.
- Sits beside the ID/EX register; the datapath forward muxes consume its selects.

---
 rtl/fwd_hazard_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the pipelined RV32I core.
//   Keeps a shadow pipeline of in-flight destination registers. Entry 0
//   is EX, and entries 1..NUM_STAGES are the forwardable stages behind it.
//   The unit decodes the opcode class of the decode-stage instruction and
//   produces two outputs:
//     - EX-stage operand forward selects (0 = register file, k = stage k).
//     - A stall/bubble request for decode when an operand will not be
//       forwardable in time.
//
// Parameters
//   NUM_STAGES  forwardable stages behind EX (2..7)
//   LOAD_READY  first stage index at which a load result is forwardable
//   ALU_READY   first stage index at which a non-load result is forwardable
//   SELW        width of each forward select
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   advance              pipeline moves this cycle (0 = freeze, state holds)
//   flush                kill the ID and EX instructions
//   id_valid             decode holds a valid instruction
//   id_opcode/rs1/rs2/rd decode-stage instruction fields
//   stall                hold PC and IF/ID, bubble into EX
//   fwd_a, fwd_b         rs1/rs2 source select for the EX instruction
//   stall_cnt, fwd_cnt   statistics counters (only with FWD_HAZARD_STATS_EN)
//
// Optional feature macro: FWD_HAZARD_STATS_EN
module fwd_hazard_unit #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned ALU_READY  = 1,
  parameter int unsigned SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  output logic            stall,
  output logic [SELW-1:0] fwd_a,
  output logic [SELW-1:0] fwd_b
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     fwd_cnt
`endif
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  // Shadow pipeline: index 0 = EX, index k = k stages behind EX.
  logic [NUM_STAGES:0] valid_q;
  logic [NUM_STAGES:0] wr_q;
  logic [NUM_STAGES:0] ld_q;
  logic [4:0]          rd_q [NUM_STAGES+1];

  // Source-operand information for the EX instruction only.
  logic       uses1_q;
  logic       uses2_q;
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;

  // Decoded decode-stage instruction.
  logic dec_uses1;
  logic dec_uses2;
  logic dec_wr;
  logic dec_ld;
  logic ex_load;

  // Hazard search scratch.
  logic found1;
  logic found2;
  logic haz1;
  logic haz2;
  logic fa_found;
  logic fb_found;

  function automatic logic ready_at(input int unsigned stage, input logic is_ld);
    return stage >= (is_ld ? LOAD_READY : ALU_READY);
  endfunction

  // Opcode-class decode. A write to x0 is treated as no write.
  always_comb begin
    dec_uses1 = 1'b0;
    dec_uses2 = 1'b0;
    dec_wr    = 1'b0;
    dec_ld    = 1'b0;
    case (opcode_e'(id_opcode))
      OP_R: begin
        dec_uses1 = 1'b1;
        dec_uses2 = 1'b1;
        dec_wr    = 1'b1;
      end
      OP_IALU, OP_JALR: begin
        dec_uses1 = 1'b1;
        dec_wr    = 1'b1;
      end
      OP_LOAD: begin
        dec_uses1 = 1'b1;
        dec_wr    = 1'b1;
        dec_ld    = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        dec_uses1 = 1'b1;
        dec_uses2 = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        dec_wr = 1'b1;
      end
      default: ;
    endcase
    if (id_rd == 5'd0) begin
      dec_wr = 1'b0;
      dec_ld = 1'b0;
    end
  end

  // Stall: for each source, only the youngest matching producer matters.
  // If that producer will still not be forwardable one stage further on,
  // decode must wait. Entry NUM_STAGES is excluded because it retires
  // into the register file on the next edge.
  always_comb begin
    found1 = 1'b0;
    found2 = 1'b0;
    haz1   = 1'b0;
    haz2   = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (!found1 && dec_uses1 && (id_rs1 != 5'd0) && valid_q[k] && wr_q[k] &&
          (rd_q[k] == id_rs1)) begin
        found1 = 1'b1;
        haz1   = !ready_at(k + 1, ld_q[k]);
      end
      if (!found2 && dec_uses2 && (id_rs2 != 5'd0) && valid_q[k] && wr_q[k] &&
          (rd_q[k] == id_rs2)) begin
        found2 = 1'b1;
        haz2   = !ready_at(k + 1, ld_q[k]);
      end
    end
    stall   = id_valid && !flush && (haz1 || haz2);
    ex_load = id_valid && !stall && !flush;
  end

  // Forward selects: the youngest matching producer behind EX wins. If it
  // is not yet forwardable, the select stays 0 rather than falling back to
  // an older producer.
  always_comb begin
    fwd_a    = '0;
    fwd_b    = '0;
    fa_found = 1'b0;
    fb_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
      if (!fa_found && uses1_q && (rs1_q != 5'd0) && valid_q[k] && wr_q[k] &&
          (rd_q[k] == rs1_q)) begin
        fa_found = 1'b1;
        if (ready_at(k, ld_q[k])) fwd_a = SELW'(k);
      end
      if (!fb_found && uses2_q && (rs2_q != 5'd0) && valid_q[k] && wr_q[k] &&
          (rd_q[k] == rs2_q)) begin
        fb_found = 1'b1;
        if (ready_at(k, ld_q[k])) fwd_b = SELW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wr_q    <= '0;
      ld_q    <= '0;
      for (int unsigned k = 0; k <= NUM_STAGES; k++) rd_q[k] <= '0;
      uses1_q <= 1'b0;
      uses2_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else if (advance) begin
      for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        wr_q[k]    <= wr_q[k-1];
        ld_q[k]    <= ld_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end
      // A flush kills the instruction leaving EX as well as the one in ID.
      valid_q[1] <= valid_q[0] && !flush;
      wr_q[1]    <= wr_q[0] && !flush;
      ld_q[1]    <= ld_q[0] && !flush;
      rd_q[1]    <= flush ? '0 : rd_q[0];

      valid_q[0] <= ex_load;
      wr_q[0]    <= ex_load && dec_wr;
      ld_q[0]    <= ex_load && dec_ld;
      rd_q[0]    <= (ex_load && dec_wr) ? id_rd : '0;
      uses1_q    <= ex_load && dec_uses1;
      uses2_q    <= ex_load && dec_uses2;
      rs1_q      <= ex_load ? id_rs1 : '0;
      rs2_q      <= ex_load ? id_rs2 : '0;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (advance) begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (((fwd_a != '0) || (fwd_b != '0)) && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Self-checking bench for fwd_hazard_unit with default parameters
//   (NUM_STAGES=3, LOAD_READY=2, ALU_READY=1). Each cycle's stimulus is
//   driven together with the outputs expected for that cycle, which are
//   queued and then compared once the DUT outputs have settled.
//   Statistics counters are checked when FWD_HAZARD_STATS_EN is defined.
module tb_fwd_hazard_unit;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_IALU = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_SYS  = 7'b1110011;

  logic       clk;
  logic       rst_n;
  logic       advance;
  logic       flush;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  fwd_hazard_unit #(
    .NUM_STAGES(3),
    .LOAD_READY(2),
    .ALU_READY (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .flush    (flush),
    .id_valid (id_valid),
    .id_opcode(id_opcode),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .id_rd    (id_rd),
    .stall    (stall),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .fwd_cnt  (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    s;
    int    a;
    int    b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   exp_sc = 0;
  int   exp_fc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive the ID instruction and controls, queue the
  // outputs expected for this cycle, then compare after they settle.
  task automatic step(input string tag, input logic v, input logic [6:0] op,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic fl, input logic adv,
                      input int es, input int ea, input int eb);
    exp_t e;
    @(negedge clk);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = r1;
    id_rs2    = r2;
    id_rd     = rd;
    flush     = fl;
    advance   = adv;
    e.tag = tag;
    e.s   = es;
    e.a   = ea;
    e.b   = eb;
    sb.push_back(e);
    if (adv && es != 0) exp_sc++;
    if (adv && (ea != 0 || eb != 0)) exp_fc++;
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".stall"}, {31'd0, stall}, e.s);
    check_eq({e.tag, ".fwd_a"}, {30'd0, fwd_a}, e.a);
    check_eq({e.tag, ".fwd_b"}, {30'd0, fwd_b}, e.b);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) idle("drain");
  endtask

  initial begin
    rst_n     = 1'b0;
    advance   = 1'b1;
    flush     = 1'b0;
    id_valid  = 1'b0;
    id_opcode = '0;
    id_rs1    = '0;
    id_rs2    = '0;
    id_rd     = '0;
    #2;
    check_eq("reset.stall", {31'd0, stall}, 0);
    check_eq("reset.fwd_a", {30'd0, fwd_a}, 0);
    check_eq("reset.fwd_b", {30'd0, fwd_b}, 0);
    #10 rst_n = 1'b1;

    // add x5,x1,x2 ; add x6,x5,x3
    step("alu1", 1, OPC_R, 5'd1, 5'd2, 5'd5, 0, 1, 0, 0, 0);
    step("alu2", 1, OPC_R, 5'd5, 5'd3, 5'd6, 0, 1, 0, 0, 0);
    step("alu_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0);
    drain();

    // lw x7,0(x1) ; add x8,x7,x7 -> one stall, then forward from stage 2
    step("lu_lw", 1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 0, 1, 0, 0, 0);
    step("lu_stall", 1, OPC_R, 5'd7, 5'd7, 5'd8, 0, 1, 1, 0, 0);
    step("lu_hold", 1, OPC_R, 5'd7, 5'd7, 5'd8, 0, 1, 0, 0, 0);
    step("lu_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 2, 2);
    drain();

    // addi x9,x0,1 ; nop ; nop ; sw x9,4(x9) -> stage 3
    step("st_addi", 1, OPC_IALU, 5'd0, 5'd0, 5'd9, 0, 1, 0, 0, 0);
    step("st_nop1", 1, OPC_IALU, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    step("st_nop2", 1, OPC_IALU, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    step("st_sw", 1, OPC_ST, 5'd9, 5'd9, 5'd4, 0, 1, 0, 0, 0);
    step("st_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 3, 3);
    drain();

    // three nops: the producer has retired before sw reaches EX
    step("st3_addi", 1, OPC_IALU, 5'd0, 5'd0, 5'd9, 0, 1, 0, 0, 0);
    step("st3_nop1", 1, OPC_IALU, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    step("st3_nop2", 1, OPC_IALU, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    step("st3_nop3", 1, OPC_IALU, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    step("st3_sw", 1, OPC_ST, 5'd9, 5'd9, 5'd4, 0, 1, 0, 0, 0);
    step("st3_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    drain();

    // add x10 ; addi x10 ; sub x11,x10,x10 -> youngest producer
    step("yg_add", 1, OPC_R, 5'd1, 5'd2, 5'd10, 0, 1, 0, 0, 0);
    step("yg_addi", 1, OPC_IALU, 5'd3, 5'd0, 5'd10, 0, 1, 0, 0, 0);
    step("yg_sub", 1, OPC_R, 5'd10, 5'd10, 5'd11, 0, 1, 0, 0, 0);
    step("yg_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1);
    drain();

    // add x0,x1,x2 ; add x3,x0,x0 -> x0 never forwards
    step("x0_add", 1, OPC_R, 5'd1, 5'd2, 5'd0, 0, 1, 0, 0, 0);
    step("x0_use", 1, OPC_R, 5'd0, 5'd0, 5'd3, 0, 1, 0, 0, 0);
    step("x0_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    // jal x0 ; jalr x4,0(x0)
    step("j_jal", 1, OPC_JAL, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    step("j_jalr", 1, OPC_JALR, 5'd0, 5'd0, 5'd4, 0, 1, 0, 0, 0);
    step("j_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    drain();

    // lw in EX, dependent add in ID, flush same cycle -> no stall, both killed
    step("fl_lw", 1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 0, 1, 0, 0, 0);
    step("fl_flush", 1, OPC_R, 5'd7, 5'd0, 5'd8, 1, 1, 0, 0, 0);
    step("fl_next", 1, OPC_R, 5'd8, 5'd7, 5'd9, 0, 1, 0, 0, 0);
    step("fl_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    drain();

    // freeze: stall still computed, state holds
    step("fz_lw", 1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 0, 1, 0, 0, 0);
    step("fz_hold1", 1, OPC_R, 5'd7, 5'd7, 5'd8, 0, 0, 1, 0, 0);
    step("fz_hold2", 1, OPC_R, 5'd7, 5'd7, 5'd8, 0, 0, 1, 0, 0);
    step("fz_stall", 1, OPC_R, 5'd7, 5'd7, 5'd8, 0, 1, 1, 0, 0);
    step("fz_go", 1, OPC_R, 5'd7, 5'd7, 5'd8, 0, 1, 0, 0, 0);
    step("fz_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 2, 2);
    drain();

    // unknown opcode reads nothing, so no load-use stall
    step("un_lw", 1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 0, 1, 0, 0, 0);
    step("un_sys", 1, OPC_SYS, 5'd7, 5'd7, 5'd7, 0, 1, 0, 0, 0);
    step("un_ex", 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    drain();

`ifdef FWD_HAZARD_STATS_EN
    #1;
    check_eq("stats.stall_cnt", stall_cnt, exp_sc);
    check_eq("stats.fwd_cnt", fwd_cnt, exp_fc);
`endif

    // reset mid-stall: add x5 ; lw x7,0(x5) ; add x8,x7,x7 then rst_n low
    step("rs_add", 1, OPC_R, 5'd1, 5'd2, 5'd5, 0, 1, 0, 0, 0);
    step("rs_lw", 1, OPC_LOAD, 5'd5, 5'd0, 5'd7, 0, 1, 0, 0, 0);
    step("rs_stall", 1, OPC_R, 5'd7, 5'd7, 5'd8, 0, 1, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rs_async.stall", {31'd0, stall}, 0);
    check_eq("rs_async.fwd_a", {30'd0, fwd_a}, 0);
    check_eq("rs_async.fwd_b", {30'd0, fwd_b}, 0);
`ifdef FWD_HAZARD_STATS_EN
    check_eq("rs_async.stall_cnt", stall_cnt, 0);
    check_eq("rs_async.fwd_cnt", fwd_cnt, 0);
`endif
    exp_sc   = 0;
    exp_fc   = 0;
    id_valid = 1'b0;
    #1 rst_n = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
